// File: rtl/debugger_uart_rx.sv
// 16x-oversampled UART receiver (8N1, or 8E1 when DEBUGGER_UART_PARITY_EN is defined)
// feeding decoded bytes to the debugger decoder as a one-cycle code_valid strobe.
module debugger_uart_rx #(
    parameter int unsigned BAUD_DIV   = 326,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy,
    output logic [2:0] state_o
);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef DEBUGGER_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_sync_q;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      phase_q, phase_d;
    logic [1:0]      samp_q, samp_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      code_q, code_d;
    logic            code_valid_q, code_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            armed_q, armed_d;
    logic            tick, bit_tick, maj;
`ifdef DEBUGGER_UART_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
    assign parity_err = parity_err_q;
`else
    logic            par_bad_q;
    assign par_bad_q  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign tick     = (state_q != ST_IDLE) && (tick_cnt_q == TW'(BAUD_DIV - 1));
    assign bit_tick = tick && (phase_q == 4'd9);
    // Majority of the samples taken on ticks 7 and 8 plus the live tick-9 sample.
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign state_o    = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (armed_q && !rx_sync_q) state_d = ST_START;
            ST_START: if (bit_tick) state_d = maj ? ST_IDLE : ST_DATA;
`ifdef DEBUGGER_UART_PARITY_EN
            ST_DATA:   if (bit_tick && bit_idx_q == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (bit_tick) state_d = ST_STOP;
`else
            ST_DATA:   if (bit_tick && bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
            ST_STOP:  if (bit_tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        armed_d      = armed_q;
`ifdef DEBUGGER_UART_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                bit_idx_d = 3'd0;
                if (rx_sync_q) armed_d = 1'b1;
            end
            ST_DATA: if (bit_tick) begin
                shift_d   = {maj, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
            end
`ifdef DEBUGGER_UART_PARITY_EN
            ST_PARITY: if (bit_tick) par_bad_d = (maj != ^shift_q);
`endif
            ST_STOP: if (bit_tick) begin
                frame_err_d = !maj;
`ifdef DEBUGGER_UART_PARITY_EN
                parity_err_d = par_bad_q;
`endif
                if (maj && !par_bad_q) begin
                    code_d       = shift_q;
                    code_valid_d = 1'b1;
                end
                // A low stop bit may be a break: wait for the line to go high first.
                if (!maj) armed_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        samp_d     = samp_q;
        if (state_q == ST_IDLE) begin
            tick_cnt_d = '0;
            phase_d    = 4'd0;
        end else if (tick) begin
            tick_cnt_d = '0;
            phase_d    = phase_q + 4'd1;
            if (phase_q == 4'd7) samp_d[0] = rx_sync_q;
            if (phase_q == 4'd8) samp_d[1] = rx_sync_q;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= IDLE_LEVEL;
            rx_sync_q    <= IDLE_LEVEL;
            tick_cnt_q   <= '0;
            phase_q      <= 4'd0;
            samp_q       <= 2'b00;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            armed_q      <= 1'b1;
`ifdef DEBUGGER_UART_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            tick_cnt_q   <= tick_cnt_d;
            phase_q      <= phase_d;
            samp_q       <= samp_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            armed_q      <= armed_d;
`ifdef DEBUGGER_UART_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end
endmodule
